// File: rtl/imm_encoder_pkg.sv
// Package imm_pkg: immediate-format enum shared with the decode-stage
// extender, the encoder payload struct, and the pure field-packing
// function used by imm_encoder.
package imm_pkg;

    localparam int IMM_W = 32;

    // Immediate formats, encoding matches the decode-stage ImmSrc field.
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_U = 3'b001,
        IMM_S = 3'b010,
        IMM_B = 3'b011,
        IMM_J = 3'b100
    } imm_src_t;

    // Encoder result; err sits in the MSB so {err, instr} packs directly.
    typedef struct packed {
        logic             err;
        logic [IMM_W-1:0] instr;
    } enc_t;

    // Packs imm into the immediate fields of base for the given format.
    // B and J immediates are in halfword units, so no shift is applied.
    // Unrepresentable immediates are flagged but still encoded truncated.
    // Unknown formats pass base through untouched and flag an error.
    function automatic enc_t encode_imm(
        input logic [IMM_W-1:0] base,
        input logic [IMM_W-1:0] imm,
        input logic [2:0]       src
    );
        enc_t r;
        r.err   = 1'b1;
        r.instr = base;
        case (src)
            IMM_I: begin
                r.instr = {imm[11:0], base[19:0]};
                r.err   = (imm != {{20{imm[11]}}, imm[11:0]});
            end
            IMM_U: begin
                r.instr = {imm[31:12], base[11:0]};
                r.err   = |imm[11:0];
            end
            IMM_S: begin
                r.instr = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
                r.err   = (imm != {{20{imm[11]}}, imm[11:0]});
            end
            IMM_B: begin
                r.instr = {imm[11], imm[9:4], base[24:12], imm[3:0], imm[10], base[6:0]};
                r.err   = (imm != {{20{imm[11]}}, imm[11:0]});
            end
            IMM_J: begin
                r.instr = {imm[19], imm[9:0], imm[10], imm[18:11], base[11:0]};
                r.err   = (imm != {{12{imm[19]}}, imm[19:0]});
            end
            default: begin
                r.instr = base;
                r.err   = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Stream interface of imm_encoder.
//  Input side : InValid/InReady handshake with ImmSrcIn, ImmIn, BaseInstrIn.
//  Output side: OutValid/OutReady handshake with InstrOut, RangeErrOut.
//  slave  : the encoder's view.  master : the producer/consumer's view.
interface imm_encoder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  InValid;
    logic                  InReady;
    logic [2:0]            ImmSrcIn;
    logic [DATA_WIDTH-1:0] ImmIn;
    logic [DATA_WIDTH-1:0] BaseInstrIn;
    logic                  OutValid;
    logic                  OutReady;
    logic [DATA_WIDTH-1:0] InstrOut;
    logic                  RangeErrOut;

    modport slave (
        input  InValid, ImmSrcIn, ImmIn, BaseInstrIn, OutReady,
        output InReady, OutValid, InstrOut, RangeErrOut
    );

    modport master (
        output InValid, ImmSrcIn, ImmIn, BaseInstrIn, OutReady,
        input  InReady, OutValid, InstrOut, RangeErrOut
    );
endinterface

// File: rtl/imm_encoder_skid.sv
// skid_buffer: generic valid/ready stage made of an output register plus a
// one-entry skid register.
//  i_in_valid/o_in_ready/i_in_data    : upstream handshake and payload
//  o_out_valid/i_out_ready/o_out_data : downstream handshake and payload
// o_in_ready is purely registered (!skid valid): no path from i_out_ready.
module skid_buffer #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data
);
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_handoff;

    assign w_handoff   = r_out_valid && i_out_ready;
    assign o_in_ready  = !r_skid_valid;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (r_skid_valid) begin
            // Input is blocked while the skid is full; drain it in order.
            if (w_handoff) begin
                r_out_data   <= r_skid_data;
                r_skid_valid <= 1'b0;
            end
        end else if (i_in_valid) begin
            // Output empty or draining this edge: load directly, no bubble.
            if (!r_out_valid || i_out_ready) begin
                r_out_data  <= i_in_data;
                r_out_valid <= 1'b1;
            end else begin
                r_skid_data  <= i_in_data;
                r_skid_valid <= 1'b1;
            end
        end else if (w_handoff) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: packs a decode-convention immediate into the immediate
// fields of a base instruction word, streamed with 1-cycle latency.
//  clk, rst_n     : clock, asynchronous active-low reset
//  bus (slave)    : input/output valid-ready streams, see imm_encoder_if
//  ErrClr         : clears ErrSticky (a simultaneous error handoff wins)
//  ErrSticky      : set when a word with RangeErrOut=1 is handed off
//  EncCount       : number of words handed off, wrapping
module imm_encoder
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    imm_encoder_if.slave       bus,
    input  logic               ErrClr,
    output logic               ErrSticky,
    output logic [COUNT_W-1:0] EncCount
);
    enc_t                  w_enc;
    logic [DATA_WIDTH:0]   w_out_data;
    logic                  w_handoff;
    logic                  r_err_sticky;
    logic [COUNT_W-1:0]    r_enc_count;

    assign w_enc = encode_imm(bus.BaseInstrIn, bus.ImmIn, bus.ImmSrcIn);

    skid_buffer #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (bus.InValid),
        .o_in_ready  (bus.InReady),
        .i_in_data   (w_enc),
        .o_out_valid (bus.OutValid),
        .i_out_ready (bus.OutReady),
        .o_out_data  (w_out_data)
    );

    assign {bus.RangeErrOut, bus.InstrOut} = w_out_data;

    assign w_handoff = bus.OutValid && bus.OutReady;
    assign ErrSticky = r_err_sticky;
    assign EncCount  = r_enc_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc_count  <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_handoff) begin
                r_enc_count <= r_enc_count + 1'b1;
            end
            if (w_handoff && bus.RangeErrOut) begin
                r_err_sticky <= 1'b1;
            end else if (ErrClr) begin
                r_err_sticky <= 1'b0;
            end
        end
    end

endmodule
